uart_rx_line_assembler: RTL and testbench
=========================================

// Module: uart_rx_line_assembler
// PURPOSE
// - Consumes bytes from the UART RX controller (one-cycle done pulse plus data byte).
// - Assembles them into newline-terminated command lines in a ping-pong pair of line buffers.
// - Presents each complete line to the downstream command parser through a random-access read port.
// - The second buffer lets reception continue while the parser reads the previous line.
// PARAMETERS
// - MAX_LINE_LEN  64                            max payload bytes per line, excluding CR/LF
// - LEN_W         $clog2(MAX_LINE_LEN+1)        width of lengths and counters
// - ADDR_W        $clog2(MAX_LINE_LEN)          width of rd_addr
// PORTS
// - clk         in   1       system clock
// - reset       in   1       synchronous, active-high reset
// - rx_valid    in   1       one-cycle pulse: rx_byte is valid (UART RX done)
// - rx_byte     in   8       received byte
// - line_valid  out  1       a complete line is held for reading
// - line_len    out  LEN_W   byte count of the held line (1..MAX_LINE_LEN)
// - rd_addr     in   ADDR_W  byte index into the held line
// - rd_data     out  8       registered read data, 1-cycle latency
// - line_ack    in   1       one-cycle pulse: consumer is done; release the line
// - overflow    out  1       one-cycle pulse: a line was discarded
// BEHAVIOUR
// - Reset values: line_valid=0, line_len=0, rd_data=0, overflow=0; full[1:0]=0; wbuf=0, rbuf=0, wcount=0; writer state W_FILL.
// - Bytes 0x0D (CR) are ignored in every writer state.
// - Byte 0x0A (LF) terminates a line.
// - Writer FSM states:
//   - W_FILL, rx_valid with LF, wcount==0: ignore (empty line).
//   - W_FILL, rx_valid with LF, wcount>0: set full[wbuf], len[wbuf]=wcount, wcount=0, wbuf toggles.
//     Next state is W_FILL if full[new wbuf]==0, else W_WAIT_FREE.
//   - W_FILL, other byte, wcount<MAX_LINE_LEN: mem[wbuf][wcount]=byte, wcount++.
//   - W_FILL, other byte, wcount==MAX_LINE_LEN: overflow pulse, wcount=0, go to W_DISCARD.
//   - W_DISCARD: drop all bytes until LF.
//     On LF: go to W_FILL if full[wbuf]==0, else W_WAIT_FREE.
//   - W_WAIT_FREE: leave when full[wbuf]==0, as registered; this is the cycle after the matching ack.
//     Any non-CR byte while waiting, including in the ack cycle: overflow pulse, go to W_DISCARD.
//     If that byte is LF, the line is complete and discarded: go directly to W_FILL or W_WAIT_FREE by the rule above.
// - Reader side:
//   - line_valid = full[rbuf], registered. line_len = len[rbuf].
//   - line_ack while line_valid: clear full[rbuf] and toggle rbuf at that edge.
//   - line_valid drops next cycle unless the other buffer is already full. In that case it stays high and line_len updates.
//   - line_ack while !line_valid is ignored.
// - rd_data <= (rd_addr < line_len) ? mem[rbuf][rd_addr] : 8'h00, sampled one cycle after rd_addr. Valid only while line_valid.
// - Simultaneous events:
//   - LF completing a buffer and line_ack in the same cycle both take effect.
//   - The full flags update independently per buffer; the ack never targets the buffer being written.
// - Line order is strictly preserved; a discarded line never becomes visible.
// - Reset mid-line or mid-read drops all buffered data and returns to the reset values above.
// STRUCTURE
// - Shared package uart_pkg:
//   - constants ASCII_LF=8'h0A and ASCII_CR=8'h0D
//   - typedef enum uart_line_wstate_t {W_FILL, W_DISCARD, W_WAIT_FREE}
// - Sub-module uart_line_mem: 2*MAX_LINE_LEN x 8 storage.
//   - One synchronous write port indexed by {wbuf, wcount}.
//   - One synchronous read port indexed by {rbuf, rd_addr}, suitable for block-RAM inference.
// - Top level holds the writer FSM, wcount, full/len registers, wbuf/rbuf and the read-mux guard.
// TESTING
// - Send "G1\r\n" -> line_valid=1, line_len=2; rd_addr 0,1 -> rd_data 0x47,0x31 one cycle later.
// - Send "A\n", "B\n" with no ack -> line_len=1, data 'A'.
//   Then line_ack -> line_valid stays high, line_len=1, data 'B'.
//   Second ack -> line_valid=0.
// - Send "\n", "\r\n" only -> line_valid stays 0, overflow never pulses.
// - Send 65 'X' then "\n", then "OK\n" (MAX=64) -> one overflow pulse on the 65th byte, no X line visible.
//   Then line_valid=1 with line_len=2, data "OK".
// - Fill both buffers ("A\n","B\n"), send "C", ack, then "D\n" -> overflow on 'C'.
//   After ack, "D" is also dropped: writer is in W_DISCARD until LF.
//   Next line "E\n" is stored behind 'B'.
// - Assert reset during "G0 X" mid-line with one line pending -> next cycle line_valid=0, line_len=0.
//   Then "Y\n" -> line_len=1, data 'Y'.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the line assembler's writer state type.
package uart_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    W_FILL,
    W_DISCARD,
    W_WAIT_FREE
  } uart_line_wstate_t;

endpackage

// File: rtl/uart_line_mem.sv
// Ping-pong line storage: one synchronous write port, one registered read port.
module uart_line_mem #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**(ADDR_W+1)];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_line_assembler.sv
// Assembles UART RX bytes into LF-terminated lines in two ping-pong buffers
// and exposes the oldest complete line through a registered read port.
module uart_rx_line_assembler
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LINE_LEN = 64,
  parameter int unsigned LEN_W        = $clog2(MAX_LINE_LEN + 1),
  parameter int unsigned ADDR_W       = $clog2(MAX_LINE_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              line_valid_o,
  output logic [LEN_W-1:0]  line_len_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  input  logic              line_ack_i,
  output logic              overflow_o
);

  uart_line_wstate_t st_q, st_d;
  logic             wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic [LEN_W-1:0] wcount_q, wcount_d;
  logic [1:0]       full_q, full_d;
  logic [LEN_W-1:0] len_q [2];
  logic [LEN_W-1:0] len_d [2];
  logic             ovf_q, ovf_d;
  logic             in_range_q, in_range_d;
  logic             we, fill_mode, is_lf, is_cr;
  logic [7:0]       mem_rdata;

  assign is_lf = (rx_byte_i == ASCII_LF);
  assign is_cr = (rx_byte_i == ASCII_CR);

  always_comb begin
    st_d       = st_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    wcount_d   = wcount_q;
    full_d     = full_q;
    len_d      = len_q;
    ovf_d      = 1'b0;
    we         = 1'b0;
    // A waiting writer whose buffer freed up last edge accepts bytes like W_FILL.
    fill_mode  = (st_q == W_FILL) || ((st_q == W_WAIT_FREE) && !full_q[wbuf_q]);
    in_range_d = LEN_W'(rd_addr_i) < len_q[rbuf_q];

    if (rx_valid_i && !is_cr) begin
      if (fill_mode) begin
        st_d = W_FILL;
        if (is_lf) begin
          if (wcount_q != '0) begin
            full_d[wbuf_q] = 1'b1;
            len_d[wbuf_q]  = wcount_q;
            wcount_d       = '0;
            wbuf_d         = ~wbuf_q;
            st_d           = full_q[~wbuf_q] ? W_WAIT_FREE : W_FILL;
          end
        end else if (wcount_q < LEN_W'(MAX_LINE_LEN)) begin
          we       = 1'b1;
          wcount_d = wcount_q + LEN_W'(1);
        end else begin
          ovf_d    = 1'b1;
          wcount_d = '0;
          st_d     = W_DISCARD;
        end
      end else if (st_q == W_DISCARD) begin
        if (is_lf) begin
          st_d = full_q[wbuf_q] ? W_WAIT_FREE : W_FILL;
        end
      end else begin
        // Still waiting and the target buffer is occupied: this line is lost.
        ovf_d = 1'b1;
        st_d  = is_lf ? W_WAIT_FREE : W_DISCARD;
      end
    end else if (fill_mode) begin
      st_d = W_FILL;
    end

    if (line_ack_i && full_q[rbuf_q]) begin
      full_d[rbuf_q] = 1'b0;
      rbuf_d         = ~rbuf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= W_FILL;
      wbuf_q     <= 1'b0;
      rbuf_q     <= 1'b0;
      wcount_q   <= '0;
      full_q     <= '0;
      len_q      <= '{default: '0};
      ovf_q      <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      wcount_q   <= wcount_d;
      full_q     <= full_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      in_range_q <= in_range_d;
    end
  end

  uart_line_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({wbuf_q, wcount_q[ADDR_W-1:0]}),
    .wdata_i (rx_byte_i),
    .raddr_i ({rbuf_q, rd_addr_i}),
    .rdata_o (mem_rdata)
  );

  assign line_valid_o = full_q[rbuf_q];
  assign line_len_o   = len_q[rbuf_q];
  assign overflow_o   = ovf_q;
  assign rd_data_o    = in_range_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_uart_rx_line_assembler.sv
// Directed bench for uart_rx_line_assembler with hand-computed expectations.
module tb_uart_rx_line_assembler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid_i = 1'b0;
  logic [7:0] rx_byte_i = 8'h00;
  logic       line_valid_o;
  logic [6:0] line_len_o;
  logic [5:0] rd_addr_i = 6'd0;
  logic [7:0] rd_data_o;
  logic       line_ack_i = 1'b0;
  logic       overflow_o;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow_o === 1'b1) ovf_cnt++;

  uart_rx_line_assembler #(
    .MAX_LINE_LEN (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid_i   (rx_valid_i),
    .rx_byte_i    (rx_byte_i),
    .line_valid_o (line_valid_o),
    .line_len_o   (line_len_o),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .line_ack_i   (line_ack_i),
    .overflow_o   (overflow_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    tick();
    rx_valid_i = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic ack();
    line_ack_i = 1'b1;
    tick();
    line_ack_i = 1'b0;
  endtask

  task automatic read_byte(input logic [5:0] a, output logic [7:0] d);
    rd_addr_i = a;
    tick();
    d = rd_data_o;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %0b want 0", line_valid_o); end
    checks++; if (line_len_o !== 7'd0) begin errors++;
      $display("FAIL reset_len: got %0d want 0", line_len_o); end
    checks++; if (rd_data_o !== 8'h00) begin errors++;
      $display("FAIL reset_rd_data: got %0h want 00", rd_data_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++;
      $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    do_reset();
    send_str("G1\r\n");
    checks++; if (line_valid_o !== 1'b1) begin errors++;
      $display("FAIL basic_valid: got %0b want 1", line_valid_o); end
    checks++; if (line_len_o !== 7'd2) begin errors++;
      $display("FAIL basic_len: got %0d want 2", line_len_o); end
    read_byte(6'd0, d);
    checks++; if (d !== 8'h47) begin errors++;
      $display("FAIL basic_byte0: got %0h want 47", d); end
    read_byte(6'd1, d);
    checks++; if (d !== 8'h31) begin errors++;
      $display("FAIL basic_byte1: got %0h want 31", d); end
    read_byte(6'd2, d);
    checks++; if (d !== 8'h00) begin errors++;
      $display("FAIL basic_oob: got %0h want 00", d); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL basic_ack: got %0b want 0", line_valid_o); end
  endtask

  task automatic test_two_lines();
    logic [7:0] d;
    do_reset();
    send_str("A\nB\n");
    read_byte(6'd0, d);
    checks++; if (line_len_o !== 7'd1 || d !== 8'h41) begin errors++;
      $display("FAIL two_first: got len %0d data %0h want 1 41", line_len_o, d); end
    ack();
    checks++; if (line_valid_o !== 1'b1) begin errors++;
      $display("FAIL two_valid_after_ack: got %0b want 1", line_valid_o); end
    read_byte(6'd0, d);
    checks++; if (line_len_o !== 7'd1 || d !== 8'h42) begin errors++;
      $display("FAIL two_second: got len %0d data %0h want 1 42", line_len_o, d); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL two_drained: got %0b want 0", line_valid_o); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL two_idle_ack: got %0b want 0", line_valid_o); end
  endtask

  task automatic test_empty();
    int base;
    do_reset();
    base = ovf_cnt;
    send_str("\n\r\n");
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL empty_valid: got %0b want 0", line_valid_o); end
    checks++; if (ovf_cnt - base !== 0) begin errors++;
      $display("FAIL empty_overflow: got %0d want 0", ovf_cnt - base); end
  endtask

  task automatic test_max_len();
    logic [7:0] d;
    int base;
    do_reset();
    base = ovf_cnt;
    for (int i = 0; i < 63; i++) send_byte(8'h5A);
    send_str("Q\n");
    checks++; if (line_valid_o !== 1'b1 || line_len_o !== 7'd64) begin errors++;
      $display("FAIL max_len: got valid %0b len %0d want 1 64", line_valid_o, line_len_o); end
    read_byte(6'd63, d);
    checks++; if (d !== 8'h51) begin errors++;
      $display("FAIL max_last_byte: got %0h want 51", d); end
    checks++; if (ovf_cnt - base !== 0) begin errors++;
      $display("FAIL max_overflow: got %0d want 0", ovf_cnt - base); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int base;
    do_reset();
    base = ovf_cnt;
    for (int i = 0; i < 64; i++) send_byte(8'h58);
    checks++; if (ovf_cnt - base !== 0) begin errors++;
      $display("FAIL ovf_early: got %0d want 0", ovf_cnt - base); end
    send_byte(8'h58);
    send_str("\nOK\n");
    checks++; if (ovf_cnt - base !== 1) begin errors++;
      $display("FAIL ovf_count: got %0d want 1", ovf_cnt - base); end
    checks++; if (line_valid_o !== 1'b1 || line_len_o !== 7'd2) begin errors++;
      $display("FAIL ovf_next_line: got valid %0b len %0d want 1 2", line_valid_o, line_len_o); end
    read_byte(6'd0, d);
    checks++; if (d !== 8'h4F) begin errors++;
      $display("FAIL ovf_byte0: got %0h want 4f", d); end
    read_byte(6'd1, d);
    checks++; if (d !== 8'h4B) begin errors++;
      $display("FAIL ovf_byte1: got %0h want 4b", d); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL ovf_no_x_line: got %0b want 0", line_valid_o); end
  endtask

  task automatic test_wait_free();
    logic [7:0] d;
    int base;
    do_reset();
    base = ovf_cnt;
    send_str("A\nB\nC");
    checks++; if (ovf_cnt - base !== 1) begin errors++;
      $display("FAIL wait_ovf_c: got %0d want 1", ovf_cnt - base); end
    ack();
    read_byte(6'd0, d);
    checks++; if (line_valid_o !== 1'b1 || d !== 8'h42) begin errors++;
      $display("FAIL wait_b_visible: got valid %0b data %0h want 1 42", line_valid_o, d); end
    send_str("D\nE\n");
    checks++; if (ovf_cnt - base !== 1) begin errors++;
      $display("FAIL wait_ovf_total: got %0d want 1", ovf_cnt - base); end
    ack();
    read_byte(6'd0, d);
    checks++; if (line_valid_o !== 1'b1 || line_len_o !== 7'd1 || d !== 8'h45) begin errors++;
      $display("FAIL wait_e_line: got valid %0b len %0d data %0h want 1 1 45",
               line_valid_o, line_len_o, d); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL wait_drained: got %0b want 0", line_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    send_str("P\nQ");
    rx_valid_i = 1'b1;
    rx_byte_i  = 8'h0A;
    line_ack_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    line_ack_i = 1'b0;
    read_byte(6'd0, d);
    checks++; if (line_valid_o !== 1'b1 || line_len_o !== 7'd1 || d !== 8'h51) begin errors++;
      $display("FAIL b2b_line: got valid %0b len %0d data %0h want 1 1 51",
               line_valid_o, line_len_o, d); end
    ack();
    checks++; if (line_valid_o !== 1'b0) begin errors++;
      $display("FAIL b2b_drained: got %0b want 0", line_valid_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    do_reset();
    send_str("A\nG0 X");
    checks++; if (line_valid_o !== 1'b1) begin errors++;
      $display("FAIL rmid_pending: got %0b want 1", line_valid_o); end
    reset = 1'b1;
    tick();
    checks++; if (line_valid_o !== 1'b0 || line_len_o !== 7'd0) begin errors++;
      $display("FAIL rmid_cleared: got valid %0b len %0d want 0 0", line_valid_o, line_len_o); end
    reset = 1'b0;
    send_str("Y\n");
    read_byte(6'd0, d);
    checks++; if (line_len_o !== 7'd1 || d !== 8'h59) begin errors++;
      $display("FAIL rmid_y_line: got len %0d data %0h want 1 59", line_len_o, d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_lines();
    test_empty();
    test_max_len();
    test_overflow();
    test_wait_free();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
